mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive lost fetch arbitrations before fetch is forced to win.
REQ-002 Parameter ADDR_W, default 32: address width. Data width is fixed at 32.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 if_req_valid_i  in  1  fetch request valid.
REQ-006 if_req_addr_i  in  ADDR_W  fetch address.
REQ-007 if_req_ready_o  out  1  fetch request accepted this cycle.
REQ-008 if_rsp_valid_o  out  1  fetch response valid, one-cycle pulse.
REQ-009 if_rsp_data_o  out  32  fetched instruction word.
REQ-010 dm_req_valid_i  in  1  data-memory request valid.
REQ-011 dm_req_addr_i  in  ADDR_W  data address.
REQ-012 dm_req_we_i  in  1  1 = store, 0 = load.
REQ-013 dm_req_wdata_i  in  32  store data.
REQ-014 dm_req_ready_o  out  1  data request accepted this cycle.
REQ-015 dm_rsp_valid_o  out  1  data response valid, one-cycle pulse.
REQ-016 dm_rsp_data_o  out  32  load data; don't-care for stores.
REQ-017 mem_req_valid_o  out  1  request issued to the shared memory port.
REQ-018 mem_req_addr_o  out  ADDR_W  issued address.
REQ-019 mem_req_we_o  out  1  issued write enable.
REQ-020 mem_req_wdata_o  out  32  issued write data.
REQ-021 mem_rsp_valid_i  in  1  memory response, including a write acknowledge.
REQ-022 mem_rsp_data_i  in  32  memory read data.
REQ-023 busy_o  out  1  a transaction is outstanding.
REQ-024 err_o  out  1  sticky protocol-error flag.

Function
REQ-025 The FSM shall have two states: IDLE and WAIT_RSP. At most one transaction shall be outstanding.
REQ-026 In IDLE, the winner shall be chosen combinationally:
- data wins over fetch;
- except when starve_cnt == STARVE_LIMIT, in which case fetch wins if if_req_valid_i is high.
REQ-027 In IDLE with any request valid, the arbiter shall:
- drive mem_req_valid_o = 1;
- drive mem_req_* from the winner, with we = 0 for fetch;
- assert the winner's ready for that cycle;
- latch owner = winner and move to WAIT_RSP.
REQ-028 A request shall be considered accepted in the cycle where valid and ready are both high; the issue latency is 0 cycles from valid to mem_req_valid_o.
REQ-029 In WAIT_RSP:
- both readys shall be 0 and mem_req_valid_o shall be 0;
- on mem_rsp_valid_i, the owner's rsp_valid_o shall pulse in that same cycle, with rsp_data_o = mem_rsp_data_i;
- the FSM shall then return to IDLE, and a new grant is possible in the next cycle at the earliest.
REQ-030 A non-owner rsp_valid_o shall be 0; both rsp_data_o outputs shall be mem_rsp_data_i whenever the FSM is in WAIT_RSP.
REQ-031 starve_cnt (width clog2(STARVE_LIMIT+1)) shall update on each IDLE grant:
- increment when data wins while if_req_valid_i is high;
- clear to 0 when fetch wins;
- otherwise hold;
- it shall never exceed STARVE_LIMIT.
REQ-032 busy_o shall equal (state == WAIT_RSP).
REQ-033 mem_rsp_valid_i asserted in IDLE shall be ignored for routing and shall set err_o; err_o shall clear only on reset.
REQ-034 A requester whose valid drops before acceptance shall not be granted; requests are not stored.
REQ-035 The design shall have no response timeout; WAIT_RSP holds indefinitely.

Reset
REQ-036 While rstn_i is low:
- state = IDLE, owner = fetch, starve_cnt = 0, err_o = 0;
- all ready, rsp_valid and mem_req_valid outputs = 0;
- data and address outputs = 0.
REQ-037 Reset asserted in WAIT_RSP shall abandon the transaction; a memory response arriving after reset release shall set err_o.

Verification
REQ-038 Fetch only, addr 0x100, mem responds 0x00500093 after 2 cycles -> if_req_ready_o = 1 in cycle 0; if_rsp_valid_o pulses in cycle 2 with data 0x00500093; busy_o high in cycles 1-2.
REQ-039 Fetch and load both valid in the same cycle -> dm wins (mem_req_addr_o = dm addr, we = 0), if_req_ready_o = 0, starve_cnt = 1.
REQ-040 dm and fetch both held valid continuously, STARVE_LIMIT = 4 -> grant order dm, dm, dm, dm, fetch, dm; starve_cnt returns to 0 after the fetch grant.
REQ-041 Store 0xDEADBEEF to 0x200, ack after 1 cycle -> mem_req_we_o = 1, mem_req_wdata_o = 0xDEADBEEF, dm_rsp_valid_o pulses; no fetch response.
REQ-042 mem_rsp_valid_i pulsed in IDLE -> err_o = 1 and stays 1; no rsp_valid pulse. Reset during WAIT_RSP -> all outputs 0 immediately; the next request is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT losses.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              clk_i,
   input  logic              rstn_i,

   input  logic              if_req_valid_i,
   input  logic [ADDR_W-1:0] if_req_addr_i,
   output logic              if_req_ready_o,
   output logic              if_rsp_valid_o,
   output logic [31:0]       if_rsp_data_o,

   input  logic              dm_req_valid_i,
   input  logic [ADDR_W-1:0] dm_req_addr_i,
   input  logic              dm_req_we_i,
   input  logic [31:0]       dm_req_wdata_i,
   output logic              dm_req_ready_o,
   output logic              dm_rsp_valid_o,
   output logic [31:0]       dm_rsp_data_o,

   output logic              mem_req_valid_o,
   output logic [ADDR_W-1:0] mem_req_addr_o,
   output logic              mem_req_we_o,
   output logic [31:0]       mem_req_wdata_o,
   input  logic              mem_rsp_valid_i,
   input  logic [31:0]       mem_rsp_data_i,

   output logic              busy_o,
   output logic              err_o
);

   localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

   typedef enum logic [0:0] {StIdle, StWaitRsp} state_e;
   typedef enum logic [0:0] {OwnFetch, OwnData} owner_e;

   state_e          state_q, state_d;
   owner_e          owner_q, owner_d;
   logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
   logic            err_q, err_d;

   logic fetch_win;
   logic data_win;
   logic grant;

   // Fetch only beats a valid data request once it has lost STARVE_LIMIT times in a row.
   always_comb begin
      fetch_win = if_req_valid_i && (!dm_req_valid_i || (starve_cnt_q == CntMax));
      data_win  = dm_req_valid_i && !fetch_win;
      grant     = (state_q == StIdle) && (fetch_win || data_win);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= StIdle;
         owner_q      <= OwnFetch;
         starve_cnt_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      starve_cnt_d = starve_cnt_q;
      err_d        = err_q;
      unique case (state_q)
         StIdle: begin
            // A response with nothing outstanding is a protocol violation.
            if (mem_rsp_valid_i) begin
               err_d = 1'b1;
            end
            if (grant) begin
               state_d = StWaitRsp;
               owner_d = data_win ? OwnData : OwnFetch;
               if (fetch_win) begin
                  starve_cnt_d = '0;
               end else if (if_req_valid_i && (starve_cnt_q != CntMax)) begin
                  starve_cnt_d = starve_cnt_q + CntW'(1);
               end
            end
         end
         StWaitRsp: begin
            if (mem_rsp_valid_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are forced low while reset is held, independent of the request inputs.
   always_comb begin
      if_req_ready_o  = 1'b0;
      dm_req_ready_o  = 1'b0;
      if_rsp_valid_o  = 1'b0;
      dm_rsp_valid_o  = 1'b0;
      if_rsp_data_o   = '0;
      dm_rsp_data_o   = '0;
      mem_req_valid_o = 1'b0;
      mem_req_addr_o  = '0;
      mem_req_we_o    = 1'b0;
      mem_req_wdata_o = '0;
      if (rstn_i) begin
         unique case (state_q)
            StIdle: begin
               mem_req_valid_o = grant;
               if (data_win) begin
                  dm_req_ready_o  = 1'b1;
                  mem_req_addr_o  = dm_req_addr_i;
                  mem_req_we_o    = dm_req_we_i;
                  mem_req_wdata_o = dm_req_wdata_i;
               end else if (fetch_win) begin
                  if_req_ready_o = 1'b1;
                  mem_req_addr_o = if_req_addr_i;
               end
            end
            StWaitRsp: begin
               if_rsp_valid_o = mem_rsp_valid_i && (owner_q == OwnFetch);
               dm_rsp_valid_o = mem_rsp_valid_i && (owner_q == OwnData);
               if_rsp_data_o  = mem_rsp_data_i;
               dm_rsp_data_o  = mem_rsp_data_i;
            end
            default: ;
         endcase
      end
   end

   assign busy_o = rstn_i && (state_q == StWaitRsp);
   assign err_o  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked against a
// transaction-level model of the arbitration and response rules.
module tb_mem_arbiter;

   localparam int unsigned STARVE_LIMIT = 4;
   localparam int unsigned ADDR_W       = 32;

   logic              clk = 1'b0;
   logic              rstn;
   logic              if_req_valid;
   logic [ADDR_W-1:0] if_req_addr;
   logic              if_req_ready;
   logic              if_rsp_valid;
   logic [31:0]       if_rsp_data;
   logic              dm_req_valid;
   logic [ADDR_W-1:0] dm_req_addr;
   logic              dm_req_we;
   logic [31:0]       dm_req_wdata;
   logic              dm_req_ready;
   logic              dm_rsp_valid;
   logic [31:0]       dm_rsp_data;
   logic              mem_req_valid;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_we;
   logic [31:0]       mem_req_wdata;
   logic              mem_rsp_valid;
   logic [31:0]       mem_rsp_data;
   logic              busy;
   logic              err;

   mem_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .ADDR_W       (ADDR_W)
   ) dut (
      .clk_i           (clk),
      .rstn_i          (rstn),
      .if_req_valid_i  (if_req_valid),
      .if_req_addr_i   (if_req_addr),
      .if_req_ready_o  (if_req_ready),
      .if_rsp_valid_o  (if_rsp_valid),
      .if_rsp_data_o   (if_rsp_data),
      .dm_req_valid_i  (dm_req_valid),
      .dm_req_addr_i   (dm_req_addr),
      .dm_req_we_i     (dm_req_we),
      .dm_req_wdata_i  (dm_req_wdata),
      .dm_req_ready_o  (dm_req_ready),
      .dm_rsp_valid_o  (dm_rsp_valid),
      .dm_rsp_data_o   (dm_rsp_data),
      .mem_req_valid_o (mem_req_valid),
      .mem_req_addr_o  (mem_req_addr),
      .mem_req_we_o    (mem_req_we),
      .mem_req_wdata_o (mem_req_wdata),
      .mem_rsp_valid_i (mem_rsp_valid),
      .mem_rsp_data_i  (mem_rsp_data),
      .busy_o          (busy),
      .err_o           (err)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Model: whether a transaction is in flight, who owns it, consecutive fetch losses, error.
   bit          m_busy      = 1'b0;
   bit          m_owner_dm  = 1'b0;
   bit          m_err       = 1'b0;
   int unsigned m_losses    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs after the falling edge, check, then advance the model.
   task automatic step(input bit rst_n, input bit ifv, input logic [31:0] ifa,
                       input bit dmv, input logic [31:0] dma, input bit dwe,
                       input logic [31:0] dwd, input bit memv, input logic [31:0] memd,
                       output logic obs_ifr, output logic obs_dmr);
      bit fw, dw;
      @(negedge clk);
      rstn          = rst_n;
      if_req_valid  = ifv;
      if_req_addr   = ifa;
      dm_req_valid  = dmv;
      dm_req_addr   = dma;
      dm_req_we     = dwe;
      dm_req_wdata  = dwd;
      mem_rsp_valid = memv;
      mem_rsp_data  = memd;
      if (!rst_n) begin
         m_busy = 1'b0; m_owner_dm = 1'b0; m_err = 1'b0; m_losses = 0;
      end
      #1;
      obs_ifr = if_req_ready;
      obs_dmr = dm_req_ready;
      fw = ifv && (!dmv || (m_losses >= STARVE_LIMIT));
      dw = dmv && !fw;
      if (!rst_n) begin
         check("rst_if_ready", if_req_ready, 0);
         check("rst_dm_ready", dm_req_ready, 0);
         check("rst_mem_valid", mem_req_valid, 0);
         check("rst_mem_addr", mem_req_addr, 0);
         check("rst_mem_we", mem_req_we, 0);
         check("rst_mem_wdata", mem_req_wdata, 0);
         check("rst_if_rsp_valid", if_rsp_valid, 0);
         check("rst_dm_rsp_valid", dm_rsp_valid, 0);
         check("rst_if_rsp_data", if_rsp_data, 0);
         check("rst_dm_rsp_data", dm_rsp_data, 0);
         check("rst_busy", busy, 0);
         check("rst_err", err, 0);
      end else if (!m_busy) begin
         check("if_ready", if_req_ready, fw);
         check("dm_ready", dm_req_ready, dw);
         check("mem_valid", mem_req_valid, ifv || dmv);
         if (fw) check("mem_addr_fetch", mem_req_addr, ifa);
         if (dw) check("mem_addr_data", mem_req_addr, dma);
         if (ifv || dmv) check("mem_we", mem_req_we, dw && dwe);
         if (dw && dwe) check("mem_wdata", mem_req_wdata, dwd);
         check("idle_if_rsp_valid", if_rsp_valid, 0);
         check("idle_dm_rsp_valid", dm_rsp_valid, 0);
         check("idle_busy", busy, 0);
         check("err", err, m_err);
      end else begin
         check("wait_if_ready", if_req_ready, 0);
         check("wait_dm_ready", dm_req_ready, 0);
         check("wait_mem_valid", mem_req_valid, 0);
         check("if_rsp_valid", if_rsp_valid, memv && !m_owner_dm);
         check("dm_rsp_valid", dm_rsp_valid, memv && m_owner_dm);
         check("if_rsp_data", if_rsp_data, memd);
         check("dm_rsp_data", dm_rsp_data, memd);
         check("wait_busy", busy, 1);
         check("err", err, m_err);
      end
      @(posedge clk);
      if (rst_n) begin
         if (!m_busy) begin
            if (memv) m_err = 1'b1;
            if (fw || dw) begin
               m_busy     = 1'b1;
               m_owner_dm = dw;
               if (fw) m_losses = 0;
               else if (ifv) m_losses++;
            end
         end else if (memv) begin
            m_busy = 1'b0;
         end
      end
   endtask

   initial begin
      logic r_if, r_dm;
      rstn = 1'b0; if_req_valid = 0; if_req_addr = '0; dm_req_valid = 0; dm_req_addr = '0;
      dm_req_we = 0; dm_req_wdata = '0; mem_rsp_valid = 0; mem_rsp_data = '0;

      // Reset held with live requests: everything must stay low.
      step(0, 1, 32'h40, 1, 32'h80, 1, 32'h1234, 1, 32'h55, r_if, r_dm);
      step(0, 1, 32'h40, 1, 32'h80, 0, 32'h0, 0, 32'h0, r_if, r_dm);

      // Fetch-only transaction, response two cycles after issue.
      step(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, r_if, r_dm);
      check("fetch_ready_c0", r_if, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, r_if, r_dm);
      step(1, 0, 0, 0, 0, 0, 0, 1, 32'h00500093, r_if, r_dm);

      // Both held valid: four data wins, then forced fetch, then data again.
      for (int g = 0; g < 6; g++) begin
         step(1, 1, 32'h104, 1, 32'h400 + 32'(g * 4), 0, 32'h0, 0, 0, r_if, r_dm);
         check("starve_order_dm", r_dm, (g == 4) ? 1'b0 : 1'b1);
         check("starve_order_if", r_if, (g == 4) ? 1'b1 : 1'b0);
         step(1, 1, 32'h104, 1, 32'h400, 0, 0, 1, $urandom, r_if, r_dm);
      end

      // Store, acknowledged one cycle later.
      step(1, 0, 0, 1, 32'h200, 1, 32'hDEADBEEF, 0, 0, r_if, r_dm);
      check("store_ready", r_dm, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 32'h0, r_if, r_dm);

      // Stray response in idle sets a sticky error.
      step(1, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE0000, r_if, r_dm);
      #1;
      check("err_set", err, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, r_if, r_dm);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, r_if, r_dm);
      #1;
      check("err_sticky", err, 1);

      // Reset in the middle of a transaction, late response, then a normal grant.
      step(1, 1, 32'h300, 0, 0, 0, 0, 0, 0, r_if, r_dm);
      step(0, 1, 32'h300, 1, 32'h304, 0, 0, 0, 0, r_if, r_dm);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, r_if, r_dm);
      step(1, 0, 0, 0, 0, 0, 0, 1, 32'h77, r_if, r_dm);
      step(1, 1, 32'h308, 0, 0, 0, 0, 0, 0, r_if, r_dm);
      check("post_reset_grant", r_if, 1);
      #1;
      check("post_reset_err", err, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 32'h88, r_if, r_dm);

      // Random traffic.
      for (int n = 0; n < 500; n++) begin
         bit rst_n, ifv, dmv, memv;
         rst_n = ($urandom_range(0, 49) != 0);
         ifv   = ($urandom_range(0, 2) != 0);
         dmv   = ($urandom_range(0, 2) != 0);
         memv  = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         step(rst_n, ifv, $urandom, dmv, $urandom, 1'($urandom), $urandom, memv, $urandom,
              r_if, r_dm);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
